// File: rtl/fft16_frame_loader.sv
// Ping-pong loader that assembles 16-sample complex frames for the 16-point FFT core.
// Latency: frame_valid rises the cycle after the closing sample; optional FFT16_LOADER_BITREV_EN stores bit-reversed.
// Backpressure: s_ready drops while both banks are full; a presented frame holds until frame_ready.
module fft16_frame_loader #(
  parameter int W = 64,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_real,
  input  logic [W-1:0]   s_im,
  input  logic           s_last,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [N*W-1:0] frame_real,
  output logic [N*W-1:0] frame_im,
  output logic [3:0]     fill_cnt,
  output logic           err_last
);

  if (N != 16) begin : g_bad_n
    $error("fft16_frame_loader: N must be 16");
  end

  logic [W-1:0] bank_re [0:1][0:15];
  logic [W-1:0] bank_im [0:1][0:15];

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic [3:0] cnt;
  logic [3:0] addr;
  logic       in_xfer;
  logic       out_xfer;
  logic       close;
  logic       early;
  logic       wr_en;

  assign s_ready     = !full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign fill_cnt    = cnt;

  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = frame_valid && frame_ready;
  assign close    = in_xfer && (cnt == 4'd15);
  // an early s_last throws away the partial frame and is itself not stored
  assign early    = in_xfer && s_last && (cnt != 4'd15);
  assign wr_en    = in_xfer && !early;

`ifdef FFT16_LOADER_BITREV_EN
  assign addr = {cnt[0], cnt[1], cnt[2], cnt[3]};
`else
  assign addr = cnt;
`endif

  // close and release can never hit the same bank: close needs it empty, release needs it full
  always_comb begin
    full_nxt = full;
    if (close)
      full_nxt[wr_bank] = 1'b1;
    if (out_xfer)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
      cnt      <= 4'd0;
      err_last <= 1'b0;
    end else begin
      full     <= full_nxt;
      err_last <= 1'b0;
      if (close) begin
        wr_bank  <= !wr_bank;
        cnt      <= 4'd0;
        err_last <= !s_last;
      end else if (early) begin
        cnt      <= 4'd0;
        err_last <= 1'b1;
      end else if (in_xfer) begin
        cnt <= cnt + 4'd1;
      end
      if (out_xfer)
        rd_bank <= !rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_re[wr_bank][addr] <= s_real;
      bank_im[wr_bank][addr] <= s_im;
    end
  end

  always_comb begin
    frame_real = '0;
    frame_im   = '0;
    for (int k = 0; k < 16; k++) begin
      frame_real[k*W +: W] = bank_re[rd_bank][k];
      frame_im[k*W +: W]   = bank_im[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fft16_frame_loader.sv
// Directed bench for fft16_frame_loader: reset, framing, backpressure and throughput scenarios.
module tb_fft16_frame_loader;
  localparam int W = 64;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_real = '0;
  logic [W-1:0]   s_im = '0;
  logic           s_last = 1'b0;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic [N*W-1:0] frame_real;
  logic [N*W-1:0] frame_im;
  logic [3:0]     fill_cnt;
  logic           err_last;

  int vecs = 0;
  int errs = 0;

  fft16_frame_loader #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_im(s_im), .s_last(s_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_real(frame_real), .frame_im(frame_im),
    .fill_cnt(fill_cnt), .err_last(err_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vecs=%0d", vecs);
    $fatal(1);
  end

  function automatic int slot_of(input int k);
    logic [3:0] c;
    c = k[3:0];
`ifdef FFT16_LOADER_BITREV_EN
    return int'({c[0], c[1], c[2], c[3]});
`else
    return int'(c);
`endif
  endfunction

  function automatic logic [W-1:0] re_at(input int slot);
    return frame_real[slot*W +: W];
  endfunction

  function automatic logic [W-1:0] im_at(input int slot);
    return frame_im[slot*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    s_valid = 1'b1;
    s_real  = re;
    s_im    = im;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    vecs++; if (fill_cnt !== 4'd0) begin errs++; $display("FAIL reset_fill_cnt got=%0d exp=0", fill_cnt); end
    vecs++; if (err_last !== 1'b0) begin errs++; $display("FAIL reset_err_last got=%b exp=0", err_last); end
    for (int k = 0; k < 7; k++) push(W'(k + 50), W'(k + 60), 1'b0);
    vecs++; if (fill_cnt !== 4'd7) begin errs++; $display("FAIL pre_reset_fill got=%0d exp=7", fill_cnt); end
    rst = 1'b1;
    #1;
    vecs++; if (fill_cnt !== 4'd0 || s_ready !== 1'b1 || frame_valid !== 1'b0) begin
      errs++; $display("FAIL midreset_state fill=%0d rdy=%b fv=%b exp 0/1/0", fill_cnt, s_ready, frame_valid);
    end
    #1;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      push(W'(200 + k), W'(300 + k), k == 15);
      if (k == 14) begin
        vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL postreset_early_frame got=%b exp=0", frame_valid); end
      end
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL postreset_frame_valid got=%b exp=1", frame_valid); end
    for (int k = 0; k < 16; k++) begin
      vecs++; if (re_at(slot_of(k)) !== W'(200 + k) || im_at(slot_of(k)) !== W'(300 + k)) begin
        errs++; $display("FAIL postreset_slot%0d re=%0d im=%0d exp %0d/%0d", slot_of(k), re_at(slot_of(k)), im_at(slot_of(k)), 200 + k, 300 + k);
      end
    end
    release_frame();
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL postreset_release got=%b exp=0", frame_valid); end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < 16; k++) begin
      push(W'(k), W'(-k), k == 15);
      if (k == 14) begin
        vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid got=%b exp=0", frame_valid); end
      end
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL single_frame_valid got=%b exp=1", frame_valid); end
    vecs++; if (err_last !== 1'b0) begin errs++; $display("FAIL single_err_last got=%b exp=0", err_last); end
`ifdef FFT16_LOADER_BITREV_EN
    vecs++; if (re_at(1) !== W'(8)) begin errs++; $display("FAIL single_slot1 got=%0d exp=8", re_at(1)); end
    vecs++; if (re_at(8) !== W'(1)) begin errs++; $display("FAIL single_slot8 got=%0d exp=1", re_at(8)); end
`else
    vecs++; if (re_at(1) !== W'(1)) begin errs++; $display("FAIL single_slot1 got=%0d exp=1", re_at(1)); end
    vecs++; if (re_at(8) !== W'(8)) begin errs++; $display("FAIL single_slot8 got=%0d exp=8", re_at(8)); end
`endif
    for (int k = 0; k < 16; k++) begin
      vecs++; if (re_at(slot_of(k)) !== W'(k) || im_at(slot_of(k)) !== W'(-k)) begin
        errs++; $display("FAIL single_slot%0d re=%h im=%h exp k=%0d", slot_of(k), re_at(slot_of(k)), im_at(slot_of(k)), k);
      end
    end
    tick();
    vecs++; if (frame_valid !== 1'b1 || re_at(slot_of(3)) !== W'(3)) begin
      errs++; $display("FAIL single_hold fv=%b re=%0d exp 1/3", frame_valid, re_at(slot_of(3)));
    end
    release_frame();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 32; k++) push(W'(k), W'(k + 1000), (k % 16) == 15);
    vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL bp_s_ready got=%b exp=0", s_ready); end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL bp_frame_valid got=%b exp=1", frame_valid); end
    s_valid = 1'b1;
    s_real  = W'(32);
    s_im    = W'(1032);
    s_last  = 1'b0;
    tick();
    tick();
    vecs++; if (s_ready !== 1'b0 || fill_cnt !== 4'd0) begin
      errs++; $display("FAIL bp_stall rdy=%b fill=%0d exp 0/0", s_ready, fill_cnt);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL bp_reraise got=%b exp=1", s_ready); end
    vecs++; if (re_at(slot_of(0)) !== W'(16)) begin errs++; $display("FAIL bp_frame1_slot got=%0d exp=16", re_at(slot_of(0))); end
    s_valid = 1'b0;
    for (int k = 32; k < 48; k++) push(W'(k), W'(k + 1000), k == 47);
    vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL bp_refull got=%b exp=0", s_ready); end
    release_frame();
    vecs++; if (frame_valid !== 1'b1 || re_at(slot_of(1)) !== W'(33) || im_at(slot_of(15)) !== W'(1047)) begin
      errs++; $display("FAIL bp_frame2 fv=%b re=%0d im=%0d exp 1/33/1047", frame_valid, re_at(slot_of(1)), im_at(slot_of(15)));
    end
    release_frame();
    vecs++; if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin
      errs++; $display("FAIL bp_drained fv=%b rdy=%b exp 0/1", frame_valid, s_ready);
    end
  endtask

  task automatic test_throughput();
    int frames;
    int drops;
    frames = 0;
    drops  = 0;
    frame_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (s_ready !== 1'b1) drops++;
      if (frame_valid === 1'b1) frames++;
      push(W'(500 + k), W'(600 + k), (k % 16) == 15);
      if ((k % 16) == 15) begin
        vecs++; if (frame_valid !== 1'b1 || re_at(slot_of(0)) !== W'(500 + k - 15)) begin
          errs++; $display("FAIL tp_frame_%0d fv=%b re=%0d exp 1/%0d", k / 16, frame_valid, re_at(slot_of(0)), 500 + k - 15);
        end
      end
    end
    if (frame_valid === 1'b1) frames++;
    tick();
    frame_ready = 1'b0;
    vecs++; if (drops !== 0) begin errs++; $display("FAIL tp_ready_drops got=%0d exp=0", drops); end
    vecs++; if (frames !== 4) begin errs++; $display("FAIL tp_frames got=%0d exp=4", frames); end
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL tp_idle got=%b exp=0", frame_valid); end
  endtask

  task automatic test_early_last();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      push(W'(900 + k), W'(950 + k), k == 5);
      if (err_last === 1'b1) pulses++;
    end
    vecs++; if (fill_cnt !== 4'd0) begin errs++; $display("FAIL early_fill got=%0d exp=0", fill_cnt); end
    for (int k = 0; k < 16; k++) begin
      push(W'(100 + k), W'(400 + k), k == 15);
      if (err_last === 1'b1) pulses++;
    end
    vecs++; if (pulses !== 1) begin errs++; $display("FAIL early_err_pulses got=%0d exp=1", pulses); end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL early_frame_valid got=%b exp=1", frame_valid); end
    for (int k = 0; k < 16; k++) begin
      vecs++; if (re_at(slot_of(k)) !== W'(100 + k) || im_at(slot_of(k)) !== W'(400 + k)) begin
        errs++; $display("FAIL early_slot%0d re=%0d im=%0d exp %0d/%0d", slot_of(k), re_at(slot_of(k)), im_at(slot_of(k)), 100 + k, 400 + k);
      end
    end
    release_frame();
  endtask

  task automatic test_missing_last();
    for (int k = 0; k < 16; k++) begin
      push(W'(700 + k), W'(800 + k), 1'b0);
      if (k == 14) begin
        vecs++; if (err_last !== 1'b0) begin errs++; $display("FAIL miss_err_early got=%b exp=0", err_last); end
      end
    end
    vecs++; if (err_last !== 1'b1) begin errs++; $display("FAIL miss_err_pulse got=%b exp=1", err_last); end
    vecs++; if (frame_valid !== 1'b1 || re_at(slot_of(15)) !== W'(715)) begin
      errs++; $display("FAIL miss_frame fv=%b re=%0d exp 1/715", frame_valid, re_at(slot_of(15)));
    end
    tick();
    vecs++; if (err_last !== 1'b0) begin errs++; $display("FAIL miss_err_clear got=%b exp=0", err_last); end
    release_frame();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_throughput();
    test_early_last();
    test_missing_last();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
